if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and owns the IF/ID pipeline register.
- Obeys the hazard unit's PCWrite/IFIDWrite stall controls.
- Accepts a branch/jump redirect from ID, which flushes the IF/ID register.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
PCWrite  in  1  1 = PC may update; 0 = hold PC (load-use stall)
IFIDWrite  in  1  1 = IF/ID register may load; 0 = hold
Redirect  in  1  taken branch/jump resolved in ID
RedirectTarget  in  32  target address for Redirect
ImemAddr  out  32  instruction-memory address (combinational = PC)
ImemInstr  in  32  instruction word returned combinationally for ImemAddr
IFIDPCPlus4  out  32  registered PC+4 of the fetched instruction
IFIDInstr  out  32  registered instruction
IFIDValid  out  1  1 = IFIDInstr is a real instruction, 0 = bubble
StallCount  out  CNT_W  cycles with a stall in effect
FlushCount  out  CNT_W  cycles with a redirect applied

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (sampled at posedge clk):
  - PC = RESET_PC with low 2 bits forced to 0.
  - IFIDPCPlus4 = 0, IFIDInstr = 32'h0 (NOP), IFIDValid = 0.
  - StallCount = 0, FlushCount = 0.
  - Reset overrides all other inputs. Reset mid-stall or mid-redirect discards that operation.
- ImemAddr = PC at all times, combinationally. No other output is combinational.
- Latency: the instruction at ImemAddr in cycle N appears on IFIDInstr in cycle N+1 when IFIDWrite=1.
- Priority per cycle, non-reset: Redirect > stall > normal.
- Redirect=1:
  - PC <= {RedirectTarget[31:2], 2'b00}.
  - IF/ID loads a bubble: IFIDInstr=0, IFIDPCPlus4=0, IFIDValid=0.
  - FlushCount++.
  - PCWrite and IFIDWrite are ignored. The redirect source guarantees it does not assert Redirect while its own operands are stalled.
- Redirect=0, normal operation:
  - If PCWrite=1: PC <= PC+4. Otherwise PC holds.
  - If IFIDWrite=1: IFIDInstr <= ImemInstr, IFIDPCPlus4 <= PC+4, IFIDValid <= 1. Otherwise all three hold.
- StallCount++ when Redirect=0 and (PCWrite=0 or IFIDWrite=0).
- PCWrite=1 with IFIDWrite=0 is legal but drops the fetched word. There is no error flag.
- Arithmetic:
  - PC+4 is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No trap.
  - Counters saturate at all-ones and never wrap.
- Held IF/ID contents are bit-exact across any number of stall cycles, including IFIDValid.

Decomposition:
- Shared package mips_pkg:
  - XLEN = 32, INSTR_W = 32.
  - NOP_INSTR = 32'h0000_0000.
  - PC_INCR = 4.
  - Both counters must be sized from the package constant CNT_W, not from literals.
- One sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count). Instantiated twice, once per performance counter.
- PC register and IF/ID register stay inline in if_stage.

Test Plan:
- Reset, then run 4 cycles with PCWrite=IFIDWrite=1, Redirect=0, and ImemInstr = 32'h1000+addr.
  -> ImemAddr = 0, 4, 8, 12.
  -> In cycle 2, IFIDInstr = 32'h1004, IFIDPCPlus4 = 8, IFIDValid = 1.
- Load-use stall: PCWrite=IFIDWrite=0 for 1 cycle at PC=8.
  -> PC stays 8 and IF/ID holds the previous instruction for exactly that cycle.
  -> StallCount = 1.
  -> The next cycle resumes at PC=12.
- Redirect=1 with RedirectTarget=32'h0000_0043 at PC=16.
  -> Next cycle: PC = 32'h40, IFIDValid = 0, IFIDInstr = 0, FlushCount = 1.
- Redirect=1 together with PCWrite=IFIDWrite=0.
  -> Redirect wins: PC = target, bubble inserted.
  -> FlushCount increments; StallCount unchanged.
- Set PC = 32'hFFFF_FFFC via redirect, then one normal cycle.
  -> PC = 0 and IFIDPCPlus4 = 0.
- Force CNT_W=4 and hold the stall for 20 cycles.
  -> StallCount = 4'hF and stays there.
  -> Assert reset mid-stall: all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline stages.
package mips_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0]    PC_INCR   = 32'd4;

  // Instruction fetches are word aligned, so the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, saturating at the maximum value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, and
// saturating stall/flush performance counters.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = mips_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCWrite,
  input  logic               IFIDWrite,
  input  logic               Redirect,
  input  logic [XLEN-1:0]    RedirectTarget,
  output logic [XLEN-1:0]    ImemAddr,
  input  logic [INSTR_W-1:0] ImemInstr,
  output logic [XLEN-1:0]    IFIDPCPlus4,
  output logic [INSTR_W-1:0] IFIDInstr,
  output logic               IFIDValid,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   FlushCount
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_plus4_s;
  logic            stall_event_s;
  logic            flush_event_s;

  assign ImemAddr   = pc_r;
  assign pc_plus4_s = pc_r + PC_INCR;

  // A redirect takes priority, so it never also counts as a stall cycle.
  always_comb begin
    flush_event_s = Redirect;
    stall_event_s = 1'b0;
    if (Redirect) begin
      stall_event_s = 1'b0;
    end else begin
      stall_event_s = !PCWrite || !IFIDWrite;
    end
  end

  // PC and IF/ID register update: redirect flushes, stalls hold contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r        <= align_word(RESET_PC);
      IFIDPCPlus4 <= '0;
      IFIDInstr   <= NOP_INSTR;
      IFIDValid   <= 1'b0;
    end else if (Redirect) begin
      pc_r        <= align_word(RedirectTarget);
      IFIDPCPlus4 <= '0;
      IFIDInstr   <= NOP_INSTR;
      IFIDValid   <= 1'b0;
    end else begin
      if (PCWrite) begin
        pc_r <= pc_plus4_s;
      end else begin
        pc_r <= pc_r;
      end
      if (IFIDWrite) begin
        IFIDPCPlus4 <= pc_plus4_s;
        IFIDInstr   <= ImemInstr;
        IFIDValid   <= 1'b1;
      end else begin
        IFIDPCPlus4 <= IFIDPCPlus4;
        IFIDInstr   <= IFIDInstr;
        IFIDValid   <= IFIDValid;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_event_s),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_event_s),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        ifid_write;
  logic        redirect;
  logic [31:0] redirect_target;

  logic [31:0] imem_addr,  imem_instr,  ifid_pcp4,  ifid_instr;
  logic        ifid_valid;
  logic [31:0] stall_cnt,  flush_cnt;

  logic [31:0] imem_addr4, imem_instr4, ifid_pcp4_4, ifid_instr4;
  logic        ifid_valid4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_pcp4, m_instr;
  logic        m_valid;
  longint      m_stall, m_flush;

  always #5 clk = ~clk;

  // Instruction memory: word content is 0x1000 plus its address.
  assign imem_instr  = 32'h0000_1000 + imem_addr;
  assign imem_instr4 = 32'h0000_1000 + imem_addr4;

  if_stage dut (
    .clk(clk), .reset(reset), .PCWrite(pc_write), .IFIDWrite(ifid_write),
    .Redirect(redirect), .RedirectTarget(redirect_target),
    .ImemAddr(imem_addr), .ImemInstr(imem_instr),
    .IFIDPCPlus4(ifid_pcp4), .IFIDInstr(ifid_instr), .IFIDValid(ifid_valid),
    .StallCount(stall_cnt), .FlushCount(flush_cnt)
  );

  if_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .PCWrite(pc_write), .IFIDWrite(ifid_write),
    .Redirect(redirect), .RedirectTarget(redirect_target),
    .ImemAddr(imem_addr4), .ImemInstr(imem_instr4),
    .IFIDPCPlus4(ifid_pcp4_4), .IFIDInstr(ifid_instr4), .IFIDValid(ifid_valid4),
    .StallCount(stall_cnt4), .FlushCount(flush_cnt4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input longint v, input longint max_v);
    return (v > max_v) ? 32'(max_v) : 32'(v);
  endfunction

  task automatic check_all();
    check_eq("imem_addr",   imem_addr,   m_pc);
    check_eq("ifid_instr",  ifid_instr,  m_instr);
    check_eq("ifid_pcp4",   ifid_pcp4,   m_pcp4);
    check_eq("ifid_valid",  {31'd0, ifid_valid}, {31'd0, m_valid});
    check_eq("stall_cnt",   stall_cnt,   sat(m_stall, 64'hFFFF_FFFF));
    check_eq("flush_cnt",   flush_cnt,   sat(m_flush, 64'hFFFF_FFFF));
    check_eq("imem_addr4",  imem_addr4,  m_pc);
    check_eq("ifid_instr4", ifid_instr4, m_instr);
    check_eq("stall_cnt4",  {28'd0, stall_cnt4}, sat(m_stall, 64'd15));
    check_eq("flush_cnt4",  {28'd0, flush_cnt4}, sat(m_flush, 64'd15));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic cycle(input logic rst, input logic pcw, input logic ifw,
                       input logic rd, input logic [31:0] tgt);
    reset = rst; pc_write = pcw; ifid_write = ifw;
    redirect = rd; redirect_target = tgt;
    if (rst) begin
      m_pc = 32'h0; m_pcp4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_stall = 0; m_flush = 0;
    end else if (rd) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_pcp4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_flush++;
    end else begin
      if (!pcw || !ifw) m_stall++;
      if (ifw) begin
        m_instr = 32'h0000_1000 + m_pc;
        m_pcp4  = m_pc + 32'd4;
        m_valid = 1'b1;
      end
      if (pcw) m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1; pc_write = 1'b0; ifid_write = 1'b0;
    redirect = 1'b0; redirect_target = 32'h0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("rst_addr",  imem_addr, 32'h0);
    check_eq("rst_valid", {31'd0, ifid_valid}, 32'h0);

    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("seq_addr1", imem_addr, 32'd4);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("seq_addr2", imem_addr, 32'd8);
    check_eq("seq_instr2", ifid_instr, 32'h0000_1004);
    check_eq("seq_pcp4_2", ifid_pcp4, 32'd8);

    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("stall_pc",    imem_addr, 32'd8);
    check_eq("stall_instr", ifid_instr, 32'h0000_1004);
    check_eq("stall_one",   stall_cnt, 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("resume_pc", imem_addr, 32'd12);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0043);
    check_eq("redir_pc",    imem_addr, 32'h0000_0040);
    check_eq("redir_instr", ifid_instr, 32'h0);
    check_eq("redir_flush", flush_cnt, 32'd1);

    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    check_eq("redir_stall_pc",  imem_addr, 32'h0000_0100);
    check_eq("redir_stall_cnt", stall_cnt, 32'd1);
    check_eq("redir_flush2",    flush_cnt, 32'd2);

    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check_eq("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("wrap_pc",   imem_addr, 32'h0);
    check_eq("wrap_pcp4", ifid_pcp4, 32'h0);

    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("sat4_stall", {28'd0, stall_cnt4}, 32'h0000_000F);
    check_eq("wide_stall", stall_cnt, 32'd21);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("midrst_stall", stall_cnt, 32'd0);
    check_eq("midrst_addr",  imem_addr, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) == 0),
            ($urandom_range(3) != 0),
            ($urandom_range(3) != 0),
            ($urandom_range(7) == 0),
            $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
